// File: rtl/fx_ctrl_pkg.sv
// Shared types, widths and clamp helpers for effect controllers.
package fx_ctrl_pkg;

    localparam int GAIN_W = 16;
    localparam int THR_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        FADE_OUT,
        FADE_IN
    } fx_ctrl_state_t;

    function automatic int clamp_s32(input int val, input int lo, input int hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    function automatic logic signed [GAIN_W-1:0] clamp_gain(
        input logic signed [GAIN_W-1:0] val,
        input int                       lo,
        input int                       hi
    );
        return GAIN_W'(clamp_s32(int'(val), lo, hi));
    endfunction

    function automatic logic signed [THR_W-1:0] clamp_thr(
        input logic signed [THR_W-1:0] val,
        input int                      lo,
        input int                      hi
    );
        return THR_W'(clamp_s32(int'(val), lo, hi));
    endfunction

endpackage

// File: rtl/distortion_ctrl_if.sv
// Configuration handshake between the user-control front end and the controller.
interface distortion_ctrl_if;

    logic                                    cfg_valid;
    logic                                    cfg_ready;
    logic signed [fx_ctrl_pkg::GAIN_W-1:0]   cfg_gain;
    logic signed [fx_ctrl_pkg::THR_W-1:0]    cfg_threshold;
    logic                                    cfg_bypass;

    modport master (
        output cfg_valid, cfg_gain, cfg_threshold, cfg_bypass,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_gain, cfg_threshold, cfg_bypass,
        output cfg_ready
    );

endinterface

// File: rtl/gain_ramp_step.sv
// One ramp step: jump to target when within STEP, otherwise move STEP toward it.
module gain_ramp_step
    import fx_ctrl_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic signed [GAIN_W-1:0] cur,
    input  logic signed [GAIN_W-1:0] tgt,
    output logic signed [GAIN_W-1:0] gain_next
);

    localparam logic signed [GAIN_W:0] STEP_W = (GAIN_W+1)'(STEP);

    logic signed [GAIN_W:0] cur_x;
    logic signed [GAIN_W:0] tgt_x;
    logic signed [GAIN_W:0] diff;
    logic signed [GAIN_W:0] moved;

    always_comb begin
        cur_x = {cur[GAIN_W-1], cur};
        tgt_x = {tgt[GAIN_W-1], tgt};
        diff  = tgt_x - cur_x;
        moved = (diff > 0) ? (cur_x + STEP_W) : (cur_x - STEP_W);
        if ((diff <= STEP_W) && (diff >= -STEP_W)) begin
            gain_next = tgt;
        end else begin
            gain_next = moved[GAIN_W-1:0];
        end
    end

endmodule

// File: rtl/distortion_ctrl.sv
// Frame-synchronous sequencer for the distortion datapath: gain ramps,
// bypass fades and threshold updates applied only on sample_tick.
module distortion_ctrl
    import fx_ctrl_pkg::*;
#(
    parameter int GAIN_MAX   = 128,
    parameter int GAIN_RESET = 1,
    parameter int THR_MIN    = 20,
    parameter int THR_MAX    = 32767,
    parameter int THR_RESET  = 50,
    parameter int RAMP_STEP  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_tick,
    distortion_ctrl_if.slave         cfg,
    output logic signed [GAIN_W-1:0] gain,
    output logic signed [THR_W-1:0]  threshold,
    output logic                     disabled,
    output logic                     busy
);

    localparam logic signed [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(GAIN_RESET);
    localparam logic signed [THR_W-1:0]  THR_INIT   = THR_W'(THR_RESET);

    fx_ctrl_state_t           state, state_n;
    logic signed [GAIN_W-1:0] tgt_gain, tgt_gain_n;
    logic signed [THR_W-1:0]  tgt_thr, tgt_thr_n;
    logic                     thr_pending, thr_pending_n;
    logic signed [GAIN_W-1:0] gain_n;
    logic signed [THR_W-1:0]  threshold_n;
    logic                     disabled_n;

    logic                     accept;
    logic signed [GAIN_W-1:0] acc_gain;
    logic signed [THR_W-1:0]  acc_thr;
    logic signed [GAIN_W-1:0] step_tgt;
    logic signed [GAIN_W-1:0] stepped;

    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign accept        = cfg.cfg_valid && (state == IDLE);
    assign acc_gain      = clamp_gain(cfg.cfg_gain, 0, GAIN_MAX);
    assign acc_thr       = clamp_thr(cfg.cfg_threshold, THR_MIN, THR_MAX);
    assign step_tgt      = (state == FADE_OUT) ? GAIN_UNITY : tgt_gain;

    gain_ramp_step #(
        .STEP (RAMP_STEP)
    ) u_step (
        .cur       (gain),
        .tgt       (step_tgt),
        .gain_next (stepped)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gain        <= GAIN_UNITY;
            threshold   <= THR_INIT;
            disabled    <= 1'b1;
            tgt_gain    <= GAIN_UNITY;
            tgt_thr     <= THR_INIT;
            thr_pending <= 1'b0;
        end else begin
            state       <= state_n;
            gain        <= gain_n;
            threshold   <= threshold_n;
            disabled    <= disabled_n;
            tgt_gain    <= tgt_gain_n;
            tgt_thr     <= tgt_thr_n;
            thr_pending <= thr_pending_n;
        end
    end

    // A tick coinciding with accept is processed first with the old state;
    // accept only happens in IDLE, where a tick never changes state.
    always_comb begin
        state_n       = state;
        gain_n        = gain;
        threshold_n   = threshold;
        disabled_n    = disabled;
        tgt_gain_n    = tgt_gain;
        tgt_thr_n     = tgt_thr;
        thr_pending_n = thr_pending;

        if (sample_tick) begin
            if (thr_pending) begin
                threshold_n   = tgt_thr;
                thr_pending_n = 1'b0;
            end
            unique case (state)
                IDLE: ;
                RAMP: begin
                    gain_n = stepped;
                    if (stepped == tgt_gain) state_n = IDLE;
                end
                FADE_OUT: begin
                    if (gain == GAIN_UNITY) begin
                        disabled_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        gain_n = stepped;
                    end
                end
                FADE_IN: begin
                    disabled_n = 1'b0;
                    state_n    = (tgt_gain == GAIN_UNITY) ? IDLE : RAMP;
                end
                default: state_n = IDLE;
            endcase
        end

        if (accept) begin
            tgt_gain_n    = acc_gain;
            tgt_thr_n     = acc_thr;
            thr_pending_n = 1'b1;
            if (cfg.cfg_bypass && !disabled) begin
                state_n = FADE_OUT;
            end else if (!cfg.cfg_bypass && disabled) begin
                state_n = FADE_IN;
            end else if (!cfg.cfg_bypass && (gain != acc_gain)) begin
                state_n = RAMP;
            end
        end
    end

endmodule

// File: tb/tb_distortion_ctrl.sv
// Directed and randomized checks of distortion_ctrl against a trajectory-queue model.
module tb_distortion_ctrl;

    localparam int GMAX  = 128;
    localparam int GRST  = 1;
    localparam int TMIN  = 20;
    localparam int TMAX  = 32767;
    localparam int TRST  = 50;
    localparam int STEP  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic [15:0] gain;
    logic [31:0] threshold;
    logic        disabled;
    logic        busy;

    distortion_ctrl_if cfg_bus ();

    distortion_ctrl #(
        .GAIN_MAX   (GMAX),
        .GAIN_RESET (GRST),
        .THR_MIN    (TMIN),
        .THR_MAX    (TMAX),
        .THR_RESET  (TRST),
        .RAMP_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .cfg         (cfg_bus.slave),
        .gain        (gain),
        .threshold   (threshold),
        .disabled    (disabled),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: each accepted config becomes a list of (gain, disabled) values,
    // one consumed per sample_tick; controller is idle when the list is empty.
    typedef struct {
        int g;
        bit d;
    } step_t;

    step_t q[$];
    int    m_gain;
    int    m_thr;
    bit    m_dis;
    int    m_tgt_thr;
    bit    m_pend;

    int n_vec = 0;
    int n_err = 0;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void plan(int from, int to, bit d);
        int g = from;
        while (g != to) begin
            if (((to - g) <= STEP) && ((g - to) <= STEP)) g = to;
            else if (to > g) g = g + STEP;
            else g = g - STEP;
            q.push_back(step_t'{g: g, d: d});
        end
    endfunction

    function automatic void m_reset();
        q.delete();
        m_gain    = GRST;
        m_thr     = TRST;
        m_dis     = 1'b1;
        m_tgt_thr = TRST;
        m_pend    = 1'b0;
    endfunction

    function automatic void m_edge(bit tick, bit acc, int g, int t, bit b);
        step_t e;
        int    tg;
        if (tick) begin
            if (m_pend) begin
                m_thr  = m_tgt_thr;
                m_pend = 1'b0;
            end
            if (q.size() > 0) begin
                e      = q.pop_front();
                m_gain = e.g;
                m_dis  = e.d;
            end
        end
        if (acc) begin
            tg        = clampi(g, 0, GMAX);
            m_tgt_thr = clampi(t, TMIN, TMAX);
            m_pend    = 1'b1;
            if (b && !m_dis) begin
                plan(m_gain, GRST, 1'b0);
                q.push_back(step_t'{g: GRST, d: 1'b1});
            end else if (!b && m_dis) begin
                q.push_back(step_t'{g: GRST, d: 1'b0});
                plan(GRST, tg, 1'b0);
            end else if (!b && !m_dis) begin
                plan(m_gain, tg, 1'b0);
            end
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    task automatic check_model();
        chk("gain",      {16'b0, gain},        32'(m_gain));
        chk("threshold", threshold,            32'(m_thr));
        chk("disabled",  {31'b0, disabled},    {31'b0, m_dis});
        chk("busy",      {31'b0, busy},        {31'b0, (q.size() != 0)});
        chk("cfg_ready", {31'b0, cfg_bus.cfg_ready}, {31'b0, (q.size() == 0)});
    endtask

    task automatic cycle(bit tick, bit v, int g, int t, bit b);
        bit acc;
        @(negedge clk);
        rst_n                 = 1'b1;
        sample_tick           = tick;
        cfg_bus.cfg_valid     = v;
        cfg_bus.cfg_gain      = 16'(g);
        cfg_bus.cfg_threshold = 32'(t);
        cfg_bus.cfg_bypass    = b;
        acc = v && (q.size() == 0);
        @(posedge clk);
        #1;
        m_edge(tick, acc, g, t, b);
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n                 = 1'b0;
        sample_tick           = 1'($urandom);
        cfg_bus.cfg_valid     = 1'($urandom);
        cfg_bus.cfg_gain      = 16'($urandom);
        cfg_bus.cfg_threshold = $urandom;
        cfg_bus.cfg_bypass    = 1'($urandom);
        @(posedge clk);
        #1;
        m_reset();
        check_model();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic run_until_idle(int budget);
        int k = 0;
        while ((q.size() != 0) && (k < budget)) begin
            cycle(1'b1, 1'b0, 0, 0, 1'b0);
            k++;
        end
        chk("idle_within_budget", {31'b0, (q.size() == 0)}, 32'd1);
    endtask

    initial begin
        int g;
        int t;
        rst_n                 = 1'b0;
        sample_tick           = 1'b0;
        cfg_bus.cfg_valid     = 1'b0;
        cfg_bus.cfg_gain      = '0;
        cfg_bus.cfg_threshold = '0;
        cfg_bus.cfg_bypass    = 1'b0;
        m_reset();

        // Reset state
        do_reset();
        do_reset();
        chk("rst_gain", {16'b0, gain}, 32'd1);
        chk("rst_thr", threshold, 32'd50);
        chk("rst_dis", {31'b0, disabled}, 32'd1);
        chk("rst_ready", {31'b0, cfg_bus.cfg_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // Fade in to gain 4
        cycle(1'b0, 1'b1, 4, 1000, 1'b0);
        chk("t2_ready_low", {31'b0, cfg_bus.cfg_ready}, 32'd0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        ticks(1);
        chk("t2_tick1_dis", {31'b0, disabled}, 32'd0);
        chk("t2_tick1_thr", threshold, 32'd1000);
        ticks(1);
        chk("t2_tick2_gain", {16'b0, gain}, 32'd2);
        ticks(2);
        chk("t2_final_gain", {16'b0, gain}, 32'd4);
        chk("t2_busy_done", {31'b0, busy}, 32'd0);

        // Clamps
        cycle(1'b0, 1'b1, -5, 5, 1'b0);
        run_until_idle(20);
        chk("t3_gain_lo", {16'b0, gain}, 32'd0);
        chk("t3_thr_lo", threshold, 32'd20);
        cycle(1'b0, 1'b1, 300, 100000, 1'b0);
        run_until_idle(200);
        chk("t3_gain_hi", {16'b0, gain}, 32'd128);
        chk("t3_thr_hi", threshold, 32'd32767);

        // Fade out from gain 4
        cycle(1'b0, 1'b1, 4, 500, 1'b0);
        run_until_idle(200);
        cycle(1'b0, 1'b1, 4, 600, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        chk("t4_no_tick", {16'b0, gain}, 32'd4);
        ticks(3);
        chk("t4_gain_unity", {16'b0, gain}, 32'd1);
        chk("t4_still_en", {31'b0, disabled}, 32'd0);
        ticks(1);
        chk("t4_bypassed", {31'b0, disabled}, 32'd1);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);

        // Accept coincident with tick while idle
        cycle(1'b1, 1'b1, 4, 1000, 1'b0);
        chk("t5_dis_held", {31'b0, disabled}, 32'd1);
        chk("t5_thr_held", threshold, 32'd600);
        ticks(1);
        chk("t5_first_step", {31'b0, disabled}, 32'd0);
        run_until_idle(20);

        // Reset mid fade-out
        cycle(1'b0, 1'b1, 4, 700, 1'b1);
        ticks(1);
        chk("t6_mid_fade", {16'b0, gain}, 32'd3);
        do_reset();
        chk("t6_gain", {16'b0, gain}, 32'd1);
        chk("t6_ready", {31'b0, cfg_bus.cfg_ready}, 32'd1);
        chk("t6_thr", threshold, 32'd50);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) g = int'($urandom_range(0, 65535)) - 32768;
                else g = int'($urandom_range(0, 12)) - 3;
                case ($urandom_range(0, 3))
                    0:       t = int'($urandom);
                    1:       t = int'($urandom_range(0, 100));
                    default: t = int'($urandom_range(0, 40000));
                endcase
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), g, t,
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
